// File: rtl/candidate_gen_pkg.sv
// Shared definitions for the NT-hash candidate generator: FSM states,
// block width and default charset bounds.
package candidate_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEmit = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned MD4_BLOCK_W    = 512;
  localparam int unsigned MAX_LEN_LIMIT  = 27;
  localparam logic [7:0]  DEF_FIRST_CHAR = 8'h21;
  localparam logic [7:0]  DEF_LAST_CHAR  = 8'h7E;

endpackage

// File: rtl/candidate_gen_block_pack.sv
// Combinational packer: candidate characters and length to a padded MD4 block
// of the UTF-16LE encoding.
module nt_block_pack
  import candidate_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic [MAX_LEN-1:0][7:0]  chars,
  input  logic [4:0]               cand_len,
  output logic [MD4_BLOCK_W-1:0]   block
);

  always_comb begin
    block = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < cand_len) begin
        block[16*i +: 8] = chars[i];
      end
    end
    // Terminator byte lands right after the last UTF-16 code unit.
    for (int i = 0; i <= MAX_LEN_LIMIT; i++) begin
      if (5'(i) == cand_len) begin
        block[16*i +: 8] = 8'h80;
      end
    end
    block[14*32 +: 32] = {23'd0, cand_len, 4'd0};
  end

endmodule

// File: rtl/candidate_gen.sv
// Password-candidate enumerator: odometer over a contiguous charset, shortest
// first, advancing only on divider tick cycles.
module candidate_gen
  import candidate_gen_pkg::*;
#(
  parameter logic [7:0]  FIRST_CHAR = DEF_FIRST_CHAR,
  parameter logic [7:0]  LAST_CHAR  = DEF_LAST_CHAR,
  parameter int unsigned MIN_LEN    = 1,
  parameter int unsigned MAX_LEN    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   block_ready,
  output logic                   block_valid,
  output logic [MD4_BLOCK_W-1:0] block,
  output logic [4:0]             cand_len,
  output logic [63:0]            cand_index,
  output logic                   busy,
  output logic                   done
);

  localparam logic [MAX_LEN-1:0][7:0] AllFirst = {MAX_LEN{FIRST_CHAR}};

  state_e                  state_q;
  logic [MAX_LEN-1:0][7:0] chars_q, chars_inc;
  logic [4:0]              len_q;
  logic [63:0]             index_q;
  logic                    valid_q, busy_q, done_q;
  logic                    carry;

  // Increment the odometer within the active length; carry out means rollover.
  always_comb begin
    chars_inc = chars_q;
    carry     = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (carry && (5'(i) < len_q)) begin
        if (chars_q[i] == LAST_CHAR) begin
          chars_inc[i] = FIRST_CHAR;
        end else begin
          chars_inc[i] = chars_q[i] + 8'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      chars_q <= AllFirst;
      len_q   <= 5'(MIN_LEN);
      index_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (tick) begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StEmit;
            chars_q <= AllFirst;
            len_q   <= 5'(MIN_LEN);
            index_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StEmit: begin
          if (block_ready) begin
            index_q <= index_q + 64'd1;
            if (carry) begin
              chars_q <= AllFirst;
              if (len_q == 5'(MAX_LEN)) begin
                state_q <= StDone;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                len_q <= len_q + 5'd1;
              end
            end else begin
              chars_q <= chars_inc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  nt_block_pack #(
    .MAX_LEN (MAX_LEN)
  ) u_pack (
    .chars    (chars_q),
    .cand_len (len_q),
    .block    (block)
  );

  assign block_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cand_len    = len_q;
  assign cand_index  = index_q;

endmodule
